// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame types and timing constants
// Purpose: state encoding, frame geometry and default filter/watchdog
// settings used by both the PS/2 receiver and the host-to-device sender.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS      = 8;
  localparam int PS2_FRAME_BITS     = 11;
  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_TIMEOUT_CYCLES = 100_000;

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer plus stability filter for a PS/2 line
// Purpose: brings an asynchronous, idle-high PS/2 line into the clk domain and
// only lets the output change once the synchronized value has differed from it
// for FILTER_LEN consecutive samples.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all stages reset to 1)
//   line  - raw asynchronous line
//   filt  - synchronized, filtered line
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic filt
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt    <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line};
      // Any sample equal to the current output restarts the run count.
      if (sync_q[1] == filt_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt_q <= sync_q[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_receive.sv
// rtl/ps2_receive.sv - PS/2 device-to-host frame receiver
// Purpose: receives start/8 data (LSB first)/odd parity/stop frames from the
// PS/2 clock and data pins (observe only) and delivers each byte as a strobe.
// Ports:
//   qzt_clk    - 50 MHz system clock
//   reset_n    - asynchronous active-low reset
//   PS2C, PS2D - raw PS/2 clock and data lines
//   enable     - 0 discards frames and holds the receiver idle
//   data       - last good byte, held until the next good frame
//   valid      - one-cycle pulse when data updates
//   parity_err - one-cycle pulse on parity mismatch
//   frame_err  - one-cycle pulse on stop bit 0 with good parity
//   timeout    - one-cycle pulse when a frame stalls mid-way
//   busy       - high while a frame is in progress
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic                     qzt_clk,
  input  logic                     reset_n,
  input  logic                     PS2C,
  input  logic                     PS2D,
  input  logic                     enable,
  output logic [PS2_DATA_BITS-1:0] data,
  output logic                     valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     timeout,
  output logic                     busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_DATA_BITS - 1);

  logic       ps2c_filt;
  logic       ps2c_filt_d;
  logic       fall_evt;
  logic [1:0] ps2d_sync;
  logic       d_smp;

  ps2_state_e               state, state_n;
  logic [3:0]               bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0] shift, shift_n;
  logic                     par_bit, par_n;
  logic [PS2_DATA_BITS-1:0] data_n;
  logic [WD_W-1:0]          wd_cnt, wd_n;
  logic                     valid_n, perr_n, ferr_n, tout_n;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_ps2c_filter (
    .clk  (qzt_clk),
    .rst_n(reset_n),
    .line (PS2C),
    .filt (ps2c_filt)
  );

  // Data needs no filtering: it is held for microseconds around the clock fall.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2d_sync   <= 2'b11;
      ps2c_filt_d <= 1'b1;
      fall_evt    <= 1'b0;
    end else begin
      ps2d_sync   <= {ps2d_sync[0], PS2D};
      ps2c_filt_d <= ps2c_filt;
      fall_evt    <= ps2c_filt_d & ~ps2c_filt;
    end
  end

  assign d_smp = ps2d_sync[1];

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      wd_cnt     <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par_bit    <= par_n;
      data       <= data_n;
      wd_cnt     <= wd_n;
      valid      <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      timeout    <= tout_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_bit;
    data_n    = data;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    tout_n    = 1'b0;

    // Watchdog restarts on every clock fall and saturates rather than wrapping.
    if (state == IDLE || fall_evt) begin
      wd_n = '0;
    end else if (wd_cnt != '1) begin
      wd_n = wd_cnt + 1'b1;
    end else begin
      wd_n = wd_cnt;
    end

    if (!enable) begin
      state_n = IDLE;
      wd_n    = '0;
    end else if (state != IDLE && !fall_evt && wd_cnt == WD_LAST) begin
      tout_n  = 1'b1;
      state_n = IDLE;
      wd_n    = '0;
    end else if (fall_evt) begin
      case (state)
        IDLE: begin
          // A high data line at a fall is not a start bit; ignore it quietly.
          if (!d_smp) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n = {d_smp, shift[PS2_DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_n = PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          par_n   = d_smp;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          // Parity failure takes precedence over a bad stop bit.
          if (!ps2_parity_ok(shift, par_bit)) begin
            perr_n = 1'b1;
          end else if (!d_smp) begin
            ferr_n = 1'b1;
          end else begin
            valid_n = 1'b1;
            data_n  = shift;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_receive.sv
// tb/tb_ps2_receive.sv - directed self-checking bench for ps2_receive
module tb_ps2_receive;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 40;
  localparam int LAT        = FILTER_LEN + 3;

  logic       qzt_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       PS2C    = 1'b1;
  logic       PS2D    = 1'b1;
  logic       enable  = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, timeout, busy;

  int tests  = 0;
  int failed = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_tout = 0, n_multi = 0;

  always #5 qzt_clk = ~qzt_clk;

  ps2_receive #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset_n   (reset_n),
    .PS2C      (PS2C),
    .PS2D      (PS2D),
    .enable    (enable),
    .data      (data),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .timeout   (timeout),
    .busy      (busy)
  );

  always @(negedge qzt_clk) begin
    if (valid)      n_valid++;
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (timeout)    n_tout++;
    if (int'(valid) + int'(parity_err) + int'(frame_err) + int'(timeout) > 1) n_multi++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge qzt_clk);
      #1;
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction

  // Drives nbits of a frame; after the last fall, lat is the number of cycles
  // from the first clk sample of that fall to the first pulse (-1 if none).
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch,
                           input int limit, output int lat, output logic mid_busy);
    lat      = -1;
    mid_busy = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      PS2D = bits[i];
      if (glitch) begin
        tick(15);
        PS2C = 1'b0;
        tick(5);
        PS2C = 1'b1;
        tick(HALF - 20);
      end else begin
        tick(HALF);
      end
      PS2C = 1'b0;
      if (i < nbits - 1) begin
        tick(HALF);
        PS2C = 1'b1;
      end
    end
    for (int j = 0; j < limit; j++) begin
      tick(1);
      if (j == 20) mid_busy = busy;
      if (valid | parity_err | frame_err | timeout) begin
        lat = j;
        break;
      end
      if (j == HALF - 1) PS2C = 1'b1;
    end
    if (PS2C == 1'b0) begin
      tick(HALF);
      PS2C = 1'b1;
    end
    PS2D = 1'b1;
    tick(HALF);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    tests++;
    if (data !== 8'h00) begin failed++; $display("FAIL reset_data got %h want 00", data); end
    tests++;
    if ({valid, parity_err, frame_err, timeout} !== 4'b0000) begin
      failed++; $display("FAIL reset_pulses got %b want 0000", {valid, parity_err, frame_err, timeout});
    end
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    reset_n = 1'b1;
    tick(20);
  endtask

  task automatic test_good_frame();
    int lat; logic mb; int v0, e0;
    v0 = n_valid; e0 = n_perr + n_ferr + n_tout;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (lat !== LAT) begin failed++; $display("FAIL good_latency got %0d want %0d", lat, LAT); end
    tests++;
    if (data !== 8'h1C) begin failed++; $display("FAIL good_data got %h want 1c", data); end
    tests++;
    if (n_valid - v0 !== 1) begin failed++; $display("FAIL good_valid_cycles got %0d want 1", n_valid - v0); end
    tests++;
    if (n_perr + n_ferr + n_tout - e0 !== 0) begin
      failed++; $display("FAIL good_errors got %0d want 0", n_perr + n_ferr + n_tout - e0);
    end
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL good_busy got %b want 0", busy); end
  endtask

  task automatic test_parity_err();
    int lat; logic mb; int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send_bits(frame(8'hAA, 1'b0, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (lat !== LAT) begin failed++; $display("FAIL perr_latency got %0d want %0d", lat, LAT); end
    tests++;
    if (n_perr - p0 !== 1) begin failed++; $display("FAIL perr_pulse got %0d want 1", n_perr - p0); end
    tests++;
    if (n_valid - v0 !== 0) begin failed++; $display("FAIL perr_valid got %0d want 0", n_valid - v0); end
    tests++;
    if (data !== 8'h1C) begin failed++; $display("FAIL perr_data got %h want 1c", data); end
  endtask

  task automatic test_frame_err();
    int lat; logic mb; int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_bits(frame(8'h55, 1'b1, 1'b0), 11, 1'b0, 30, lat, mb);
    tests++;
    if (n_ferr - f0 !== 1) begin failed++; $display("FAIL ferr_pulse got %0d want 1", n_ferr - f0); end
    tests++;
    if (n_perr - p0 + n_valid - v0 !== 0) begin
      failed++; $display("FAIL ferr_other got %0d want 0", n_perr - p0 + n_valid - v0);
    end
    tests++;
    if (data !== 8'h1C) begin failed++; $display("FAIL ferr_data got %h want 1c", data); end
  endtask

  task automatic test_timeout();
    int lat; logic mb; int t0, v0;
    t0 = n_tout;
    send_bits(frame(8'h00, 1'b1, 1'b1), 6, 1'b0, TIMEOUT + 100, lat, mb);
    // The watchdog restarts when the fall is processed, LAT cycles after the pin.
    tests++;
    if (lat !== LAT + TIMEOUT) begin failed++; $display("FAIL tout_latency got %0d want %0d", lat, LAT + TIMEOUT); end
    tests++;
    if (mb !== 1'b1) begin failed++; $display("FAIL tout_busy_before got %b want 1", mb); end
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL tout_busy_after got %b want 0", busy); end
    tests++;
    if (n_tout - t0 !== 1) begin failed++; $display("FAIL tout_pulse got %0d want 1", n_tout - t0); end
    v0 = n_valid;
    send_bits(frame(8'hF0, 1'b1, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (data !== 8'hF0 || n_valid - v0 !== 1) begin
      failed++; $display("FAIL tout_recover got data %h valid %0d want f0 1", data, n_valid - v0);
    end
  endtask

  task automatic test_glitch();
    int lat; logic mb; int v0, e0;
    v0 = n_valid; e0 = n_perr + n_ferr + n_tout;
    send_bits(frame(8'h3A, 1'b1, 1'b1), 11, 1'b1, 30, lat, mb);
    tests++;
    if (data !== 8'h3A) begin failed++; $display("FAIL glitch_data got %h want 3a", data); end
    tests++;
    if (n_valid - v0 !== 1 || n_perr + n_ferr + n_tout - e0 !== 0) begin
      failed++; $display("FAIL glitch_pulses got valid %0d err %0d want 1 0", n_valid - v0, n_perr + n_ferr + n_tout - e0);
    end
  endtask

  task automatic test_enable();
    int lat; logic mb;
    enable = 1'b0;
    send_bits(frame(8'h77, 1'b1, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (lat !== -1 || data !== 8'h3A) begin
      failed++; $display("FAIL enable_discard got lat %0d data %h want -1 3a", lat, data);
    end
    enable = 1'b1;
    tick(5);
  endtask

  task automatic test_reset_mid_frame();
    int lat; logic mb; int v0;
    v0 = n_valid;
    send_bits(frame(8'h12, 1'b1, 1'b1), 5, 1'b0, HALF + 5, lat, mb);
    tests++;
    if (mb !== 1'b1 || lat !== -1) begin failed++; $display("FAIL midrst_partial got busy %b lat %0d want 1 -1", mb, lat); end
    @(posedge qzt_clk);
    #3;
    reset_n = 1'b0;
    #1;
    tests++;
    if (data !== 8'h00 || busy !== 1'b0 || {valid, parity_err, frame_err, timeout} !== 4'b0000) begin
      failed++; $display("FAIL midrst_outputs got data %h busy %b want 00 0", data, busy);
    end
    tick(3);
    reset_n = 1'b1;
    tick(5);
    send_bits(frame(8'h12, 1'b1, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (data !== 8'h12 || n_valid - v0 !== 1) begin
      failed++; $display("FAIL midrst_recover got data %h valid %0d want 12 1", data, n_valid - v0);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic mb; int v0;
    v0 = n_valid;
    send_bits(frame(8'h12, 1'b1, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (data !== 8'h12) begin failed++; $display("FAIL b2b_first got %h want 12", data); end
    send_bits(frame(8'h34, 1'b0, 1'b1), 11, 1'b0, 30, lat, mb);
    tests++;
    if (data !== 8'h34 || n_valid - v0 !== 2) begin
      failed++; $display("FAIL b2b_second got data %h valid %0d want 34 2", data, n_valid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_enable();
    test_reset_mid_frame();
    test_back_to_back();
    tests++;
    if (n_multi !== 0) begin failed++; $display("FAIL pulse_exclusive got %0d want 0", n_multi); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
